nios2_oci_dct_packer: RTL and testbench

Transmit-side packer for the Nios II OCI direct-branch compression trace (DCT). It accepts per-instruction 2-bit branch codes from the CPU trace tap and accumulates them into a 30-bit `dct_buffer` with a 4-bit `dct_count`. When a frame closes, it hands the frame to the trace-memory path over a valid/ready handshake. This block produces the `dct_buffer`/`dct_count` pair that the OCI test bench and the trace unit consume.

---
 rtl/nios2_oci_dct_pkg.sv | 27 ++
 rtl/nios2_oci_dct_packer_frame_reg.sv | 36 +++
 rtl/nios2_oci_dct_packer.sv | 106 ++++++++++
 tb/tb_nios2_oci_dct_packer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_oci_dct_pkg.sv
// Shared constants and types for the OCI direct-branch compression trace packer.
// NIOS2_OCI_DCT_PARITY_EN widens the outgoing frame by one even-parity bit.
package nios2_oci_dct_pkg;

    localparam int DCT_CODE_W = 2;
    localparam int DCT_DEPTH  = 15;
    localparam int DCT_BUF_W  = 30;
    localparam int DCT_CNT_W  = 4;

`ifdef NIOS2_OCI_DCT_PARITY_EN
    localparam int DCT_FRM_W  = DCT_CNT_W + DCT_BUF_W + 1;
`else
    localparam int DCT_FRM_W  = DCT_CNT_W + DCT_BUF_W;
`endif

    typedef enum logic [1:0] {
        ACCUM,
        PEND,
        FULL
    } dct_state_e;

    typedef struct packed {
        logic [DCT_CNT_W-1:0] count;
        logic [DCT_BUF_W-1:0] buffer;
    } dct_frame_t;

endpackage

// File: rtl/nios2_oci_dct_packer_frame_reg.sv
// One-entry valid/ready holding register for closed DCT frames.
// NIOS2_OCI_DCT_PARITY_EN adds an even-parity bit above the frame.
module nios2_oci_dct_frame_reg
    import nios2_oci_dct_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  dct_frame_t           frame,
    input  logic                 ready,
    output logic                 valid,
    output logic [DCT_FRM_W-1:0] data
);

    logic [DCT_FRM_W-1:0] data_in;

`ifdef NIOS2_OCI_DCT_PARITY_EN
    assign data_in = {^frame, frame};
`else
    assign data_in = frame;
`endif

    // load is only raised when the slot is free, so it always wins over ready
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nios2_oci_dct_packer.sv
// DCT transmit packer: accumulates 2-bit branch codes into 15-code frames.
// NIOS2_OCI_DCT_PARITY_EN selects a 35-bit frm_data carrying even parity.
module nios2_oci_dct_packer
    import nios2_oci_dct_pkg::*;
#(
    parameter int IDLE_FLUSH_CYCLES = 0
)
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ev_valid,
    input  logic [DCT_CODE_W-1:0] ev_code,
    output logic                  ev_ready,
    input  logic                  flush,
    output logic [DCT_BUF_W-1:0]  dct_buffer,
    output logic [DCT_CNT_W-1:0]  dct_count,
    output logic                  frm_valid,
    input  logic                  frm_ready,
    output logic [DCT_FRM_W-1:0]  frm_data
);

    localparam int TMR_W = (IDLE_FLUSH_CYCLES > 1) ? $clog2(IDLE_FLUSH_CYCLES + 1) : 1;
    localparam logic [TMR_W-1:0]     TMR_LIMIT = TMR_W'(IDLE_FLUSH_CYCLES);
    localparam logic [DCT_CNT_W-1:0] CNT_FULL  = DCT_CNT_W'(DCT_DEPTH);

    dct_state_e             state, state_nxt;
    logic [DCT_BUF_W-1:0]   buf_q, buf_nxt, post_buf;
    logic [DCT_CNT_W-1:0]   cnt_q, cnt_nxt, post_cnt;
    logic [TMR_W-1:0]       tmr_q, tmr_nxt;
    logic                   accept;
    logic                   slot_free;
    logic                   idle_close;
    logic                   close_req;
    logic                   frm_load;
    dct_frame_t             frame_in;

    assign ev_ready   = (cnt_q != CNT_FULL);
    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ACCUM;
            buf_q <= '0;
            cnt_q <= '0;
            tmr_q <= '0;
        end else begin
            state <= state_nxt;
            buf_q <= buf_nxt;
            cnt_q <= cnt_nxt;
            tmr_q <= tmr_nxt;
        end
    end

    always_comb begin
        accept    = ev_valid && ev_ready;
        slot_free = !frm_valid || frm_ready;

        post_buf = buf_q;
        post_cnt = cnt_q;
        if (accept) begin
            post_buf = {buf_q[DCT_BUF_W-DCT_CODE_W-1:0], ev_code};
            post_cnt = cnt_q + 1'b1;
        end

        idle_close = (IDLE_FLUSH_CYCLES != 0) && (cnt_q != '0) && (tmr_q == TMR_LIMIT);

        // PEND and FULL both mean a close is owed; the frame always takes post-append content
        close_req = (state != ACCUM) || (post_cnt == CNT_FULL)
                 || (flush && (post_cnt != '0)) || idle_close;

        state_nxt = ACCUM;
        buf_nxt   = post_buf;
        cnt_nxt   = post_cnt;
        frm_load  = 1'b0;
        frame_in  = '{count: post_cnt, buffer: post_buf};

        if (close_req) begin
            if (slot_free) begin
                frm_load = 1'b1;
                buf_nxt  = '0;
                cnt_nxt  = '0;
            end else begin
                state_nxt = (post_cnt == CNT_FULL) ? FULL : PEND;
            end
        end

        tmr_nxt = tmr_q;
        if ((IDLE_FLUSH_CYCLES == 0) || accept || close_req) begin
            tmr_nxt = '0;
        end else if ((cnt_q != '0) && (tmr_q != TMR_LIMIT)) begin
            tmr_nxt = tmr_q + 1'b1;
        end
    end

    nios2_oci_dct_frame_reg u_frame_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (frm_load),
        .frame   (frame_in),
        .ready   (frm_ready),
        .valid   (frm_valid),
        .data    (frm_data)
    );

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Self-checking bench for nios2_oci_dct_packer against a queue-based frame model.
// Honours NIOS2_OCI_DCT_PARITY_EN for the frame width and parity bit.
module tb_nios2_oci_dct_packer;

`ifdef NIOS2_OCI_DCT_PARITY_EN
    localparam int FW = 35;
`else
    localparam int FW = 34;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ev_valid, flush, frm_ready;
    logic [1:0]    ev_code;
    logic          ev_ready, frm_valid;
    logic [29:0]   dct_buffer;
    logic [3:0]    dct_count;
    logic [FW-1:0] frm_data;

    logic          i_ev_valid, i_flush, i_frm_ready;
    logic [1:0]    i_ev_code;
    logic          i_ev_ready, i_frm_valid;
    logic [29:0]   i_dct_buffer;
    logic [3:0]    i_dct_count;
    logic [FW-1:0] i_frm_data;

    always #5 clk = ~clk;

    nios2_oci_dct_packer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ev_valid   (ev_valid),
        .ev_code    (ev_code),
        .ev_ready   (ev_ready),
        .flush      (flush),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .frm_valid  (frm_valid),
        .frm_ready  (frm_ready),
        .frm_data   (frm_data)
    );

    nios2_oci_dct_packer #(.IDLE_FLUSH_CYCLES(8)) dut_idle (
        .clk        (clk),
        .reset_n    (reset_n),
        .ev_valid   (i_ev_valid),
        .ev_code    (i_ev_code),
        .ev_ready   (i_ev_ready),
        .flush      (i_flush),
        .dct_buffer (i_dct_buffer),
        .dct_count  (i_dct_count),
        .frm_valid  (i_frm_valid),
        .frm_ready  (i_frm_ready),
        .frm_data   (i_frm_data)
    );

    int tests = 0;
    int fails = 0;

    // reference model: live codes, frame slot and an owed-close flag
    int unsigned   q[$];
    bit            m_valid;
    logic [FW-1:0] m_data;
    bit            owed;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] pack_codes(input int unsigned c[$]);
        longint unsigned r = 0;
        foreach (c[i]) r = r * 4 + longint'(c[i]);
        return r[29:0];
    endfunction

    function automatic logic [FW-1:0] mk_frame(input int unsigned cnt, input logic [29:0] b);
        logic [33:0] f;
        f = {cnt[3:0], b};
`ifdef NIOS2_OCI_DCT_PARITY_EN
        return {^f, f};
`else
        return f;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_data  = '0;
        owed    = 1'b0;
    endtask

    task automatic step(input bit v, input logic [1:0] c, input bit fl, input bit rdy);
        bit acc, free, want;
        ev_valid  = v;
        ev_code   = c;
        flush     = fl;
        frm_ready = rdy;
        chk("ev_ready", ev_ready, q.size() != 15);
        acc  = v && (q.size() != 15);
        free = !m_valid || rdy;
        if (acc) q.push_back(int'(c));
        want = owed || (q.size() == 15) || (fl && q.size() > 0);
        if (want && free) begin
            m_valid = 1'b1;
            m_data  = mk_frame(q.size(), pack_codes(q));
            q.delete();
            owed = 1'b0;
        end else begin
            if (want) owed = 1'b1;
            if (rdy) m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("dct_count", dct_count, q.size());
        chk("dct_buffer", dct_buffer, pack_codes(q));
        chk("frm_valid", frm_valid, m_valid);
        chk("frm_data", frm_data, m_data);
    endtask

    initial begin
        int lat;
        reset_n   = 1'b0;
        ev_valid  = 1'b0;
        ev_code   = 2'b00;
        flush     = 1'b0;
        frm_ready = 1'b0;
        i_ev_valid = 1'b0;
        i_ev_code  = 2'b00;
        i_flush    = 1'b0;
        i_frm_ready = 1'b1;
        model_reset();
        #12;
        chk("rst_buffer", dct_buffer, 30'h0);
        chk("rst_count", dct_count, 4'h0);
        chk("rst_frm_valid", frm_valid, 1'b0);
        chk("rst_frm_data", frm_data, '0);
        chk("rst_ev_ready", ev_ready, 1'b1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // fill and emit with the consumer always ready
        for (int i = 0; i < 15; i++) step(1, 2'b01, 0, 1);
        chk("fill_frame", frm_data, mk_frame(15, 30'h15555555));
        chk("fill_count", dct_count, 4'h0);
        step(0, 2'b00, 0, 1);

        // partial frame flush, then a flush with nothing buffered
        step(1, 2'b01, 0, 1);
        step(1, 2'b00, 0, 1);
        step(1, 2'b10, 0, 1);
        step(0, 2'b00, 1, 1);
        chk("flush_frame", frm_data, mk_frame(3, 30'h12));
        step(0, 2'b00, 0, 1);
        step(0, 2'b00, 1, 1);
        chk("empty_flush", frm_valid, 1'b0);

        // flush together with an event at count 4
        step(1, 2'b01, 0, 1);
        step(1, 2'b10, 0, 1);
        step(1, 2'b00, 0, 1);
        step(1, 2'b01, 0, 1);
        step(1, 2'b11, 1, 1);
        chk("flush_ev_frame", frm_data, mk_frame(5, 30'h187));
        step(0, 2'b00, 0, 1);

        // backpressure: two full frames against a stalled consumer
        for (int i = 0; i < 30; i++) step(1, 2'($urandom), 0, 0);
        chk("bp_count", dct_count, 4'hF);
        chk("bp_ev_ready", ev_ready, 1'b0);
        chk("bp_frm_valid", frm_valid, 1'b1);
        step(0, 2'b00, 0, 1);
        chk("bp_release_ready", ev_ready, 1'b1);
        chk("bp_release_valid", frm_valid, 1'b1);
        step(0, 2'b00, 0, 1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, 2'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 6);
        end
        step(0, 2'b00, 1, 1);
        step(0, 2'b00, 0, 1);
        step(0, 2'b00, 0, 1);

        // idle flush disabled: a partial frame never closes on its own
        step(1, 2'b01, 0, 1);
        step(1, 2'b01, 0, 1);
        for (int i = 0; i < 20; i++) step(0, 2'b00, 0, 1);
        chk("no_idle_frame", frm_valid, 1'b0);
        step(0, 2'b00, 1, 1);
        step(0, 2'b00, 0, 1);

        // idle flush after 8 idle cycles on the second instance
        chk("idle_ev_ready", i_ev_ready, 1'b1);
        i_ev_valid = 1'b1;
        i_ev_code  = 2'b01;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        i_ev_valid = 1'b0;
        chk("idle_count", i_dct_count, 4'h2);
        chk("idle_buffer", i_dct_buffer, 30'h5);
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (i_frm_valid && lat == 0) begin
                lat = k;
                chk("idle_frame", i_frm_data, mk_frame(2, 30'h5));
                chk("idle_cleared", i_dct_count, 4'h0);
            end
        end
        chk("idle_latency", lat, 9);

        // reset with a frame held and a flush pending at count 7
        for (int i = 0; i < 22; i++) step(1, 2'($urandom), 0, 0);
        step(0, 2'b00, 1, 0);
        chk("pre_rst_count", dct_count, 4'h7);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_buffer", dct_buffer, 30'h0);
        chk("mid_rst_count", dct_count, 4'h0);
        chk("mid_rst_frm_valid", frm_valid, 1'b0);
        chk("mid_rst_frm_data", frm_data, '0);
        chk("mid_rst_ev_ready", ev_ready, 1'b1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1, 2'b10, 0, 1);
        chk("post_rst_count", dct_count, 4'h1);
        step(0, 2'b00, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
